apb4_mem_bridge: RTL and testbench



---
 rtl/apb4_mem_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_apb4_mem_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_mem_bridge.sv
// ---------------------------------------------------------------------------
// apb4_mem_bridge
//
// APB4 completer that turns each APB transfer into a one-cycle read or write
// request pulse on a simple multi-channel memory interface. It waits for the
// selected channel to report completion or an error, and then returns a
// registered PREADY/PSLVERR/PRDATA.
//
// Ports
//   PCLK, PRESETn         clock (rising edge) and async active-low reset
//   PADDR, PSELx          APB address and per-channel select
//   PENABLE, PWRITE       APB access phase and direction
//   PWDATA, PSTRB, PPROT  APB write data, byte strobes and protection
//   PREADY, PSLVERR       registered transfer done / error
//   PRDATA                registered read data
//   read, write           one-cycle request pulses, one bit per channel
//   address, write_data   captured address and write data
//   write_strb, prot      captured strobes (zero for reads) and PPROT
//   read_data             memory read data, valid with access_complete
//   access_complete       per-channel completion
//   invalid_access        per-channel access error
//   invalid_address       per-channel address error
//   timeout_event         one-cycle pulse when a wait timeout fires
// ---------------------------------------------------------------------------
module apb4_mem_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int PSEL_WIDTH = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [PSEL_WIDTH-1:0]     PSELx,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    input  logic [2:0]                PPROT,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic [PSEL_WIDTH-1:0]     read,
    output logic [PSEL_WIDTH-1:0]     write,
    output logic [ADDR_WIDTH-1:0]     address,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic [DATA_WIDTH/8-1:0]   write_strb,
    output logic [2:0]                prot,
    input  logic [DATA_WIDTH-1:0]     read_data,
    input  logic [PSEL_WIDTH-1:0]     access_complete,
    input  logic [PSEL_WIDTH-1:0]     invalid_access,
    input  logic [PSEL_WIDTH-1:0]     invalid_address,
    output logic                      timeout_event
);

    localparam int STRB_W = DATA_WIDTH / 8;
    // Counter only has to hold 0 .. TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic TO_EN = (TIMEOUT > 0);
    localparam logic [PSEL_WIDTH-1:0] ONE_SEL = PSEL_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_onehot(input logic [PSEL_WIDTH-1:0] v);
        return (v != '0) && ((v & (v - ONE_SEL)) == '0);
    endfunction

    state_t                  state_r;
    logic [PSEL_WIDTH-1:0]   sel_r;
    logic                    pwrite_r;
    logic [CNT_W-1:0]        wait_cnt_r;
    logic                    pready_r;
    logic                    pslverr_r;
    logic [DATA_WIDTH-1:0]   prdata_r;
    logic [PSEL_WIDTH-1:0]   read_r;
    logic [PSEL_WIDTH-1:0]   write_r;
    logic [ADDR_WIDTH-1:0]   address_r;
    logic [DATA_WIDTH-1:0]   write_data_r;
    logic [STRB_W-1:0]       write_strb_r;
    logic [2:0]              prot_r;
    logic                    timeout_event_r;

    logic setup_s;
    logic sel_live_s;
    logic cmp_hit_s;
    logic err_hit_s;
    logic timeout_hit_s;

    // Setup detection and flag sampling restricted to the captured channel.
    always_comb begin
        setup_s       = (|PSELx) && !PENABLE;
        sel_live_s    = |PSELx;
        cmp_hit_s     = |(access_complete & sel_r);
        err_hit_s     = |((invalid_access | invalid_address) & sel_r);
        timeout_hit_s = TO_EN && (wait_cnt_r == TO_LAST);
    end

    // Transfer FSM with all bus-facing outputs registered.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r         <= ST_IDLE;
            sel_r           <= '0;
            pwrite_r        <= 1'b0;
            wait_cnt_r      <= '0;
            pready_r        <= 1'b0;
            pslverr_r       <= 1'b0;
            prdata_r        <= '0;
            read_r          <= '0;
            write_r         <= '0;
            address_r       <= '0;
            write_data_r    <= '0;
            write_strb_r    <= '0;
            prot_r          <= 3'b000;
            timeout_event_r <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised for exactly one cycle.
            read_r          <= '0;
            write_r         <= '0;
            pready_r        <= 1'b0;
            pslverr_r       <= 1'b0;
            timeout_event_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (setup_s) begin
                        address_r    <= PADDR;
                        write_data_r <= PWDATA;
                        write_strb_r <= PWRITE ? PSTRB : '0;
                        prot_r       <= PPROT;
                        sel_r        <= PSELx;
                        pwrite_r     <= PWRITE;
                        wait_cnt_r   <= '0;
                        if (is_onehot(PSELx)) begin
                            state_r <= ST_REQ;
                            if (PWRITE) begin
                                write_r <= PSELx;
                            end else begin
                                read_r <= PSELx;
                            end
                        end else begin
                            // Ambiguous select: never touch memory, fail at once.
                            state_r   <= ST_DONE;
                            pready_r  <= 1'b1;
                            pslverr_r <= 1'b1;
                            if (!PWRITE) begin
                                prdata_r <= '0;
                            end
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (!sel_live_s) begin
                        // Requester abandoned the transfer: no PREADY.
                        state_r <= ST_IDLE;
                    end else if (err_hit_s) begin
                        // Error takes priority over a simultaneous completion.
                        state_r   <= ST_DONE;
                        pready_r  <= 1'b1;
                        pslverr_r <= 1'b1;
                        if (!pwrite_r) begin
                            prdata_r <= '0;
                        end
                    end else if (cmp_hit_s) begin
                        state_r  <= ST_DONE;
                        pready_r <= 1'b1;
                        if (!pwrite_r) begin
                            prdata_r <= read_data;
                        end
                    end else if ((state_r == ST_WAIT) && timeout_hit_s) begin
                        state_r         <= ST_DONE;
                        pready_r        <= 1'b1;
                        pslverr_r       <= 1'b1;
                        timeout_event_r <= 1'b1;
                        if (!pwrite_r) begin
                            prdata_r <= '0;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                        if (state_r == ST_REQ) begin
                            wait_cnt_r <= '0;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign PREADY        = pready_r;
    assign PSLVERR       = pslverr_r;
    assign PRDATA        = prdata_r;
    assign read          = read_r;
    assign write         = write_r;
    assign address       = address_r;
    assign write_data    = write_data_r;
    assign write_strb    = write_strb_r;
    assign prot          = prot_r;
    assign timeout_event = timeout_event_r;

endmodule

// File: tb/tb_apb4_mem_bridge.sv
module tb_apb4_mem_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic [1:0]  PSELx;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] read_data;
    logic [1:0]  access_complete;
    logic [1:0]  invalid_access;
    logic [1:0]  invalid_address;

    logic        PREADY, PSLVERR, timeout_event;
    logic [31:0] PRDATA, address, write_data;
    logic [1:0]  rd, wr;
    logic [3:0]  write_strb;
    logic [2:0]  prot;

    logic        n_PREADY, n_PSLVERR, n_timeout_event;
    logic [31:0] n_PRDATA, n_address, n_write_data;
    logic [1:0]  n_rd, n_wr;
    logic [3:0]  n_write_strb;
    logic [2:0]  n_prot;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 PCLK = ~PCLK;

    apb4_mem_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PSEL_WIDTH(2), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
        .read(rd), .write(wr), .address(address), .write_data(write_data),
        .write_strb(write_strb), .prot(prot), .read_data(read_data),
        .access_complete(access_complete), .invalid_access(invalid_access),
        .invalid_address(invalid_address), .timeout_event(timeout_event)
    );

    apb4_mem_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .PSEL_WIDTH(2), .TIMEOUT(0)) dut_nt (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PREADY(n_PREADY), .PSLVERR(n_PSLVERR), .PRDATA(n_PRDATA),
        .read(n_rd), .write(n_wr), .address(n_address), .write_data(n_write_data),
        .write_strb(n_write_strb), .prot(n_prot), .read_data(read_data),
        .access_complete(access_complete), .invalid_access(invalid_access),
        .invalid_address(invalid_address), .timeout_event(n_timeout_event)
    );

    // Each bench cycle starts 1 time unit after the rising edge.
    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic bus_idle;
        PSELx = 2'b00; PENABLE = 1'b0; PWRITE = 1'b0;
        access_complete = 2'b00; invalid_access = 2'b00; invalid_address = 2'b00;
    endtask

    task automatic setup_phase(input logic [1:0] sel, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        PSELx = sel; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s; PPROT = p;
    endtask

    task automatic test_reset;
        PRESETn = 1'b0; bus_idle(); PADDR = 32'h0000_1234; PWDATA = 32'h0;
        PSTRB = 4'h0; PPROT = 3'b000; read_data = 32'h0;
        tick(); tick();
        if (PREADY !== 1'b0) begin $display("FAIL reset_pready got %b want 0", PREADY); n_mis++; end n_cmp++;
        if (PSLVERR !== 1'b0) begin $display("FAIL reset_pslverr got %b want 0", PSLVERR); n_mis++; end n_cmp++;
        if (PRDATA !== 32'h0) begin $display("FAIL reset_prdata got %h want 0", PRDATA); n_mis++; end n_cmp++;
        if ({rd, wr} !== 4'b0000) begin $display("FAIL reset_req got %b want 0000", {rd, wr}); n_mis++; end n_cmp++;
        if (timeout_event !== 1'b0) begin $display("FAIL reset_tev got %b want 0", timeout_event); n_mis++; end n_cmp++;
        PRESETn = 1'b1;
        tick();
    endtask

    task automatic test_write_ch1;
        setup_phase(2'b10, 1'b1, 32'h40, 32'hDEADBEEF, 4'h3, 3'b001);
        tick(); // T1
        if (wr !== 2'b10) begin $display("FAIL wr1_write got %b want 10", wr); n_mis++; end n_cmp++;
        if (rd !== 2'b00) begin $display("FAIL wr1_read got %b want 00", rd); n_mis++; end n_cmp++;
        if (write_strb !== 4'h3) begin $display("FAIL wr1_strb got %h want 3", write_strb); n_mis++; end n_cmp++;
        if (address !== 32'h40) begin $display("FAIL wr1_addr got %h want 40", address); n_mis++; end n_cmp++;
        if (write_data !== 32'hDEADBEEF) begin $display("FAIL wr1_wdata got %h want deadbeef", write_data); n_mis++; end n_cmp++;
        if (prot !== 3'b001) begin $display("FAIL wr1_prot got %b want 001", prot); n_mis++; end n_cmp++;
        if (PREADY !== 1'b0) begin $display("FAIL wr1_pready_t1 got %b want 0", PREADY); n_mis++; end n_cmp++;
        PENABLE = 1'b1; access_complete = 2'b10;
        tick(); // T2
        if (PREADY !== 1'b1) begin $display("FAIL wr1_pready_t2 got %b want 1", PREADY); n_mis++; end n_cmp++;
        if (PSLVERR !== 1'b0) begin $display("FAIL wr1_pslverr got %b want 0", PSLVERR); n_mis++; end n_cmp++;
        if (wr !== 2'b00) begin $display("FAIL wr1_write_t2 got %b want 00", wr); n_mis++; end n_cmp++;
        if (PRDATA !== 32'h0) begin $display("FAIL wr1_prdata_hold got %h want 0", PRDATA); n_mis++; end n_cmp++;
        bus_idle();
        tick(); // T3
        if (PREADY !== 1'b0) begin $display("FAIL wr1_pready_t3 got %b want 0", PREADY); n_mis++; end n_cmp++;
    endtask

    task automatic test_read_wait;
        int pulses;
        setup_phase(2'b01, 1'b0, 32'h80, 32'hFFFFFFFF, 4'hF, 3'b010);
        tick(); // T1
        pulses = (rd != 2'b00) ? 1 : 0;
        if (rd !== 2'b01) begin $display("FAIL rdw_read got %b want 01", rd); n_mis++; end n_cmp++;
        if (write_strb !== 4'h0) begin $display("FAIL rdw_strb got %h want 0", write_strb); n_mis++; end n_cmp++;
        if (prot !== 3'b010) begin $display("FAIL rdw_prot got %b want 010", prot); n_mis++; end n_cmp++;
        PENABLE = 1'b1;
        for (int t = 2; t <= 6; t++) begin
            tick();
            if (rd != 2'b00) pulses++;
            if (t < 6) begin
                if (PREADY !== 1'b0) begin $display("FAIL rdw_early_pready t=%0d got %b want 0", t, PREADY); n_mis++; end n_cmp++;
            end
            if (t == 5) begin
                access_complete = 2'b01; read_data = 32'h12345678;
            end
        end
        if (PREADY !== 1'b1) begin $display("FAIL rdw_pready_t6 got %b want 1", PREADY); n_mis++; end n_cmp++;
        if (PSLVERR !== 1'b0) begin $display("FAIL rdw_pslverr got %b want 0", PSLVERR); n_mis++; end n_cmp++;
        if (PRDATA !== 32'h12345678) begin $display("FAIL rdw_prdata got %h want 12345678", PRDATA); n_mis++; end n_cmp++;
        if (pulses !== 1) begin $display("FAIL rdw_pulses got %0d want 1", pulses); n_mis++; end n_cmp++;
        bus_idle(); read_data = 32'h0;
        tick();
    endtask

    task automatic test_error_priority;
        setup_phase(2'b01, 1'b0, 32'h84, 32'h0, 4'hF, 3'b000);
        tick(); // T1
        PENABLE = 1'b1; invalid_address = 2'b01; access_complete = 2'b01; read_data = 32'hCAFEF00D;
        tick(); // T2
        if (PREADY !== 1'b1) begin $display("FAIL errp_pready got %b want 1", PREADY); n_mis++; end n_cmp++;
        if (PSLVERR !== 1'b1) begin $display("FAIL errp_pslverr got %b want 1", PSLVERR); n_mis++; end n_cmp++;
        if (PRDATA !== 32'h0) begin $display("FAIL errp_prdata got %h want 0", PRDATA); n_mis++; end n_cmp++;
        bus_idle(); read_data = 32'h0;
        tick();
    endtask

    task automatic test_wrong_channel;
        setup_phase(2'b01, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
        tick(); // T1
        PENABLE = 1'b1; access_complete = 2'b10; invalid_address = 2'b10; invalid_access = 2'b10;
        tick(); // T2
        if (PREADY !== 1'b0) begin $display("FAIL wch_ignored got %b want 0", PREADY); n_mis++; end n_cmp++;
        access_complete = 2'b01; invalid_address = 2'b00; invalid_access = 2'b00; read_data = 32'h600DF00D;
        tick(); // T3
        if (PREADY !== 1'b1) begin $display("FAIL wch_pready got %b want 1", PREADY); n_mis++; end n_cmp++;
        if (PSLVERR !== 1'b0) begin $display("FAIL wch_pslverr got %b want 0", PSLVERR); n_mis++; end n_cmp++;
        if (PRDATA !== 32'h600DF00D) begin $display("FAIL wch_prdata got %h want 600df00d", PRDATA); n_mis++; end n_cmp++;
        bus_idle(); read_data = 32'h0;
        tick();
    endtask

    task automatic test_timeout;
        logic nt_seen;
        setup_phase(2'b10, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
        tick(); // T1
        PENABLE = 1'b1;
        for (int t = 2; t <= 17; t++) begin
            tick();
            if (PREADY !== 1'b0 || timeout_event !== 1'b0) begin
                $display("FAIL to_early t=%0d got pready=%b tev=%b want 0/0", t, PREADY, timeout_event); n_mis++;
            end
            n_cmp++;
        end
        tick(); // T18
        if (PREADY !== 1'b1) begin $display("FAIL to_pready got %b want 1", PREADY); n_mis++; end n_cmp++;
        if (PSLVERR !== 1'b1) begin $display("FAIL to_pslverr got %b want 1", PSLVERR); n_mis++; end n_cmp++;
        if (timeout_event !== 1'b1) begin $display("FAIL to_event got %b want 1", timeout_event); n_mis++; end n_cmp++;
        if (PRDATA !== 32'h0) begin $display("FAIL to_prdata got %h want 0", PRDATA); n_mis++; end n_cmp++;
        nt_seen = n_PREADY;
        tick(); // T19
        if (timeout_event !== 1'b0) begin $display("FAIL to_event_pulse got %b want 0", timeout_event); n_mis++; end n_cmp++;
        for (int t = 20; t <= 40; t++) begin
            nt_seen = nt_seen | n_PREADY;
            tick();
        end
        if (nt_seen !== 1'b0) begin $display("FAIL to0_waits got %b want 0", nt_seen); n_mis++; end n_cmp++;
        bus_idle();
        tick(); tick();
        if (n_PREADY !== 1'b0) begin $display("FAIL to0_abort got %b want 0", n_PREADY); n_mis++; end n_cmp++;
    endtask

    task automatic test_bad_select;
        setup_phase(2'b11, 1'b1, 32'h50, 32'h55AA55AA, 4'hF, 3'b000);
        tick(); // T1
        if ({rd, wr} !== 4'b0000) begin $display("FAIL bsel_req got %b want 0000", {rd, wr}); n_mis++; end n_cmp++;
        if (PREADY !== 1'b1) begin $display("FAIL bsel_pready got %b want 1", PREADY); n_mis++; end n_cmp++;
        if (PSLVERR !== 1'b1) begin $display("FAIL bsel_pslverr got %b want 1", PSLVERR); n_mis++; end n_cmp++;
        PENABLE = 1'b1;
        tick(); // T2
        if (PREADY !== 1'b0) begin $display("FAIL bsel_pready_t2 got %b want 0", PREADY); n_mis++; end n_cmp++;
        bus_idle();
        tick();
    endtask

    task automatic test_abort;
        setup_phase(2'b01, 1'b0, 32'h60, 32'h0, 4'h0, 3'b000);
        tick(); // T1
        PENABLE = 1'b1;
        tick(); // T2 (WAIT)
        PSELx = 2'b00; PENABLE = 1'b0;
        tick(); // T3
        if (PREADY !== 1'b0) begin $display("FAIL abort_t3 got %b want 0", PREADY); n_mis++; end n_cmp++;
        access_complete = 2'b01; read_data = 32'h11111111;
        tick(); // T4
        if (PREADY !== 1'b0) begin $display("FAIL abort_late_flag got %b want 0", PREADY); n_mis++; end n_cmp++;
        access_complete = 2'b00;
        setup_phase(2'b01, 1'b1, 32'h64, 32'h0000BEEF, 4'h1, 3'b000);
        tick();
        if (wr !== 2'b01) begin $display("FAIL abort_idle_setup got %b want 01", wr); n_mis++; end n_cmp++;
        PENABLE = 1'b1; access_complete = 2'b01;
        tick();
        if (PREADY !== 1'b1) begin $display("FAIL abort_next_pready got %b want 1", PREADY); n_mis++; end n_cmp++;
        bus_idle(); read_data = 32'h0;
        tick();
    endtask

    task automatic test_back_to_back;
        setup_phase(2'b01, 1'b1, 32'h10, 32'h11112222, 4'hF, 3'b000);
        tick(); // T1
        PENABLE = 1'b1; access_complete = 2'b01;
        tick(); // T2 (DONE)
        if (PREADY !== 1'b1) begin $display("FAIL b2b_first got %b want 1", PREADY); n_mis++; end n_cmp++;
        tick(); // T3: setup directly after DONE
        access_complete = 2'b00;
        setup_phase(2'b01, 1'b0, 32'h14, 32'h0, 4'hF, 3'b000);
        if (PREADY !== 1'b0) begin $display("FAIL b2b_gap got %b want 0", PREADY); n_mis++; end n_cmp++;
        tick(); // T4
        if (rd !== 2'b01) begin $display("FAIL b2b_read got %b want 01", rd); n_mis++; end n_cmp++;
        if (address !== 32'h14) begin $display("FAIL b2b_addr got %h want 14", address); n_mis++; end n_cmp++;
        PENABLE = 1'b1; access_complete = 2'b01; read_data = 32'hA5A55A5A;
        tick(); // T5
        if (PREADY !== 1'b1) begin $display("FAIL b2b_second got %b want 1", PREADY); n_mis++; end n_cmp++;
        if (PRDATA !== 32'hA5A55A5A) begin $display("FAIL b2b_prdata got %h want a5a55a5a", PRDATA); n_mis++; end n_cmp++;
        bus_idle(); read_data = 32'h0;
        tick();
    endtask

    task automatic test_reset_mid;
        setup_phase(2'b10, 1'b1, 32'h70, 32'h87654321, 4'hF, 3'b111);
        tick(); // T1
        if (wr !== 2'b10) begin $display("FAIL rmid_write got %b want 10", wr); n_mis++; end n_cmp++;
        PENABLE = 1'b1;
        tick(); // T2 (WAIT)
        PRESETn = 1'b0;
        #1;
        if (PRDATA !== 32'h0) begin $display("FAIL rmid_prdata got %h want 0", PRDATA); n_mis++; end n_cmp++;
        if (address !== 32'h0) begin $display("FAIL rmid_addr got %h want 0", address); n_mis++; end n_cmp++;
        if (write_data !== 32'h0) begin $display("FAIL rmid_wdata got %h want 0", write_data); n_mis++; end n_cmp++;
        if ({write_strb, prot} !== 7'h00) begin $display("FAIL rmid_strb_prot got %h want 0", {write_strb, prot}); n_mis++; end n_cmp++;
        if ({PREADY, PSLVERR, timeout_event, rd, wr} !== 7'h00) begin
            $display("FAIL rmid_flags got %b want 0", {PREADY, PSLVERR, timeout_event, rd, wr}); n_mis++;
        end
        n_cmp++;
        bus_idle();
        #1 PRESETn = 1'b1;
        tick();
        setup_phase(2'b01, 1'b1, 32'h74, 32'h0BADF00D, 4'hC, 3'b000);
        tick(); // T1
        if (wr !== 2'b01) begin $display("FAIL rmid_fresh_write got %b want 01", wr); n_mis++; end n_cmp++;
        PENABLE = 1'b1; access_complete = 2'b01;
        tick(); // T2
        if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
            $display("FAIL rmid_fresh_done got pready=%b pslverr=%b want 1/0", PREADY, PSLVERR); n_mis++;
        end
        n_cmp++;
        bus_idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_ch1();
        test_read_wait();
        test_error_priority();
        test_wrong_channel();
        test_timeout();
        test_bad_select();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
